// File: rtl/rst_seq_gen.sv
`default_nettype none
// ============================================================================
// rst_seq_gen : DCM reset pulse, lock filter and staggered release of N reset domains
// Rev 1.0
// ============================================================================
module rst_seq_gen #(
  parameter int N_DOMAINS    = 4,
  parameter int DCM_RST_CYC  = 4,
  parameter int LOCK_FILT    = 64,
  parameter int LOCK_TMO     = 65536,
  parameter int STRETCH_CYC  = 256,
  parameter int STAGGER_CYC  = 16,
  parameter int DEBOUNCE_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 locked,
  input  logic                 sw_rst,
  output logic                 dcm_reset,
  output logic [N_DOMAINS-1:0] rst_out,
  output logic                 ready,
  output logic [7:0]           lock_loss_cnt,
  output logic [3:0]           retry_cnt
);

  localparam int M_A     = (DCM_RST_CYC > LOCK_TMO) ? DCM_RST_CYC : LOCK_TMO;
  localparam int M_B     = (STRETCH_CYC > STAGGER_CYC) ? STRETCH_CYC : STAGGER_CYC;
  localparam int CNT_MAX = (M_A > M_B) ? M_A : M_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FILT_W  = $clog2(LOCK_FILT + 1);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int IDX_W   = $clog2(N_DOMAINS + 1);

  localparam logic [CNT_W-1:0]  C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_DCM      = CNT_W'(DCM_RST_CYC);
  localparam logic [CNT_W-1:0]  C_TMO      = CNT_W'(LOCK_TMO);
  localparam logic [CNT_W-1:0]  C_STRETCH  = CNT_W'(STRETCH_CYC);
  localparam logic [CNT_W-1:0]  C_STAGGER  = CNT_W'(STAGGER_CYC);
  localparam logic [FILT_W-1:0] C_FILT     = FILT_W'(LOCK_FILT);
  localparam logic [DEB_W-1:0]  C_DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(N_DOMAINS - 1);

  localparam logic [2:0] ST_ASSERT    = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STRETCH   = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           loss_q, loss_d;
  logic [3:0]           retry_q, retry_d;
  logic                 lk_meta_q, lk_meta_d, lk_sync_q, lk_sync_d;
  logic                 sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic                 btn_lvl_q, btn_lvl_d;
  logic [DEB_W-1:0]     dbc_q, dbc_d;
  logic [FILT_W-1:0]    filt_q, filt_d;
  logic                 dcm_reset_q, dcm_reset_d;
  logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                 ready_q, ready_d;
  logic                 btn_rise, lock_good, lock_lost;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      idx_q       <= '0;
      loss_q      <= '0;
      retry_q     <= '0;
      lk_meta_q   <= 1'b0;
      lk_sync_q   <= 1'b0;
      sw_meta_q   <= 1'b0;
      sw_sync_q   <= 1'b0;
      btn_lvl_q   <= 1'b0;
      dbc_q       <= '0;
      filt_q      <= '0;
      dcm_reset_q <= 1'b1;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      lk_meta_q   <= lk_meta_d;
      lk_sync_q   <= lk_sync_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      btn_lvl_q   <= btn_lvl_d;
      dbc_q       <= dbc_d;
      filt_q      <= filt_d;
      dcm_reset_q <= dcm_reset_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
    end
  end

  // Synchronisers and button debounce; the filtered level flips on the
  // DEBOUNCE_CYC-th consecutive sample that disagrees with it.
  always_comb begin
    lk_meta_d = locked;
    lk_sync_d = lk_meta_q;
    sw_meta_d = sw_rst;
    sw_sync_d = sw_meta_q;
    btn_lvl_d = btn_lvl_q;
    dbc_d     = '0;
    if (sw_sync_q != btn_lvl_q) begin
      if (dbc_q == C_DEB_LAST) begin
        btn_lvl_d = sw_sync_q;
      end else begin
        dbc_d = dbc_q + 1'b1;
      end
    end
    btn_rise  = btn_lvl_d & ~btn_lvl_q;
    lock_good = (filt_q == C_FILT);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    loss_d    = loss_q;
    retry_d   = retry_q;
    lock_lost = ~lk_sync_q &
                ((state_q == ST_STRETCH) || (state_q == ST_RELEASE) || (state_q == ST_RUN));
    if (state_q == ST_ASSERT) begin
      if (btn_rise) begin
        cnt_d = C_ONE;
      end else if (cnt_q == C_DCM) begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = C_ONE;
      end
    end else if (btn_rise || lock_lost) begin
      state_d = ST_ASSERT;
      cnt_d   = C_ONE;
      if (lock_lost && (loss_q != 8'hFF)) begin
        loss_d = loss_q + 8'd1;
      end
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (lock_good) begin
            state_d = ST_STRETCH;
            cnt_d   = C_ONE;
          end else if (cnt_q == C_TMO) begin
            state_d = ST_ASSERT;
            cnt_d   = C_ONE;
            if (retry_q != 4'hF) begin
              retry_d = retry_q + 4'd1;
            end
          end
        end
        ST_STRETCH: begin
          if (cnt_q == C_STRETCH) begin
            state_d = ST_RELEASE;
            cnt_d   = C_ONE;
            idx_d   = '0;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == C_STAGGER) begin
            cnt_d = C_ONE;
            if (idx_q == C_IDX_LAST) begin
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Outputs decode the next state so they move on the transition edge.
  always_comb begin
    dcm_reset_d = (state_d == ST_ASSERT);
    ready_d     = (state_d == ST_RUN);
    for (int i = 0; i < N_DOMAINS; i++) begin
      rst_out_d[i] = ~((state_d == ST_RUN) ||
                       ((state_d == ST_RELEASE) && (IDX_W'(i) <= idx_d)));
    end
  end

  always_comb begin
    if (dcm_reset_d || !lk_sync_q) begin
      filt_d = '0;
    end else if (filt_q == C_FILT) begin
      filt_d = filt_q;
    end else begin
      filt_d = filt_q + 1'b1;
    end
  end

  assign dcm_reset     = dcm_reset_q;
  assign rst_out       = rst_out_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_q;
  assign retry_cnt     = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_gen.sv
`default_nettype none
// ============================================================================
// tb_rst_seq_gen : self-checking bench for rst_seq_gen (timestamp-based reference model)
// Rev 1.0
// ============================================================================
module tb_rst_seq_gen;

  localparam int P_N    = 3;
  localparam int P_DCM  = 4;
  localparam int P_FILT = 8;
  localparam int P_TMO  = 100;
  localparam int P_STR  = 16;
  localparam int P_STAG = 4;
  localparam int P_DEB  = 8;

  logic       clk = 1'b0;
  logic       reset, locked, sw_rst;
  logic       dcm_reset, ready;
  logic [2:0] rst_out;
  logic [7:0] lock_loss_cnt;
  logic [3:0] retry_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  rst_seq_gen #(
    .N_DOMAINS(P_N), .DCM_RST_CYC(P_DCM), .LOCK_FILT(P_FILT), .LOCK_TMO(P_TMO),
    .STRETCH_CYC(P_STR), .STAGGER_CYC(P_STAG), .DEBOUNCE_CYC(P_DEB)
  ) dut (
    .clk(clk), .reset(reset), .locked(locked), .sw_rst(sw_rst),
    .dcm_reset(dcm_reset), .rst_out(rst_out), .ready(ready),
    .lock_loss_cnt(lock_loss_cnt), .retry_cnt(retry_cnt)
  );

  initial forever #5 clk = ~clk;

  // Reference model: phase plus event timestamps; release times are arithmetic
  // offsets from the moment the stretch phase began.
  int       m_n, m_phase, m_a_until, m_t_wait, m_t_seq, m_hi_run;
  int       m_run_len, m_loss, m_retry;
  bit [1:0] m_lk_pipe, m_sw_pipe;
  bit       m_lvl, m_run_val;

  function automatic void model_step();
    bit sl, ss, old_lvl, rise, good;
    if (reset) begin
      m_n = -1; m_phase = 0; m_a_until = P_DCM; m_hi_run = 0;
      m_t_wait = 0; m_t_seq = 0; m_lk_pipe = '0; m_sw_pipe = '0;
      m_lvl = 0; m_run_val = 0; m_run_len = 0; m_loss = 0; m_retry = 0;
      return;
    end
    m_n++;
    sl = m_lk_pipe[1];
    ss = m_sw_pipe[1];
    m_lk_pipe = {m_lk_pipe[0], locked};
    m_sw_pipe = {m_sw_pipe[0], sw_rst};
    if (ss == m_run_val) m_run_len++;
    else begin m_run_val = ss; m_run_len = 1; end
    old_lvl = m_lvl;
    if (m_run_val != m_lvl && m_run_len >= P_DEB) m_lvl = m_run_val;
    rise = m_lvl && !old_lvl;
    good = (m_hi_run >= P_FILT);
    if (m_phase == 0) begin
      if (rise) m_a_until = m_n + P_DCM;
      else if (m_n == m_a_until) begin m_phase = 1; m_t_wait = m_n; end
    end else if (m_phase == 1) begin
      if (rise) begin m_phase = 0; m_a_until = m_n + P_DCM; end
      else if (good) begin m_phase = 2; m_t_seq = m_n; end
      else if (m_n - m_t_wait == P_TMO) begin
        m_phase = 0; m_a_until = m_n + P_DCM;
        if (m_retry < 15) m_retry++;
      end
    end else begin
      if (rise || !sl) begin
        m_phase = 0; m_a_until = m_n + P_DCM;
        if (!sl && m_loss < 255) m_loss++;
      end
    end
    m_hi_run = (m_phase == 0 || !sl) ? 0 : m_hi_run + 1;
  endfunction

  function automatic logic [2:0] exp_rst();
    logic [2:0] r = 3'b111;
    if (m_phase == 2)
      for (int i = 0; i < P_N; i++)
        if (m_n - m_t_seq >= P_STR + i * P_STAG) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic exp_ready();
    return (m_phase == 2) && (m_n - m_t_seq >= P_STR + P_N * P_STAG);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_dcm_reset", dcm_reset, m_phase == 0);
    chk("model_rst_out", rst_out, exp_rst());
    chk("model_ready", ready, exp_ready());
    chk("model_lock_loss_cnt", lock_loss_cnt, m_loss);
    chk("model_retry_cnt", retry_cnt, m_retry);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (!ready && k < budget) begin cycle(); k++; end
    chk("wait_ready_in_budget", ready, 1);
  endtask

  task automatic wait_rst(input logic [2:0] v, input int budget);
    int k = 0;
    while (rst_out != v && k < budget) begin cycle(); k++; end
    chk("wait_rst_out_in_budget", rst_out, v);
  endtask

  typedef struct {
    int         cyc;
    logic       dcm;
    logic [2:0] rst;
    logic       rdy;
  } vec_t;

  initial begin
    vec_t tv[10];
    int   falls, found;
    logic prev;

    tv[0] = '{3,  1'b1, 3'b111, 1'b0};
    tv[1] = '{4,  1'b0, 3'b111, 1'b0};
    tv[2] = '{27, 1'b0, 3'b111, 1'b0};
    tv[3] = '{28, 1'b0, 3'b110, 1'b0};
    tv[4] = '{31, 1'b0, 3'b110, 1'b0};
    tv[5] = '{32, 1'b0, 3'b100, 1'b0};
    tv[6] = '{35, 1'b0, 3'b100, 1'b0};
    tv[7] = '{36, 1'b0, 3'b000, 1'b0};
    tv[8] = '{39, 1'b0, 3'b000, 1'b0};
    tv[9] = '{40, 1'b0, 3'b000, 1'b1};

    reset = 1'b1; locked = 1'b1; sw_rst = 1'b0;
    repeat (3) cycle();
    chk("reset_dcm_reset", dcm_reset, 1);
    chk("reset_rst_out", rst_out, 3'b111);
    chk("reset_ready", ready, 0);
    chk("reset_counts", {lock_loss_cnt, retry_cnt}, 0);
    reset = 1'b0;

    // Clean power-up sequence against absolute cycle numbers
    for (int c = 0; c < 45; c++) begin
      cycle();
      foreach (tv[k]) begin
        if (tv[k].cyc == c) begin
          chk($sformatf("seq_c%0d_dcm_reset", c), dcm_reset, tv[k].dcm);
          chk($sformatf("seq_c%0d_rst_out", c), rst_out, tv[k].rst);
          chk($sformatf("seq_c%0d_ready", c), ready, tv[k].rdy);
        end
      end
    end

    // One-cycle lock drop in RUN
    locked = 1'b0; cycle();
    locked = 1'b1; cycle(); cycle();
    chk("lockdrop_rst_out", rst_out, 3'b111);
    chk("lockdrop_ready", ready, 0);
    chk("lockdrop_loss_cnt", lock_loss_cnt, 1);
    wait_ready(200);

    // Reset in the middle of RELEASE with idx=1
    locked = 1'b0; cycle();
    locked = 1'b1;
    wait_rst(3'b100, 200);
    reset = 1'b1; cycle();
    chk("midrel_rst_out", rst_out, 3'b111);
    chk("midrel_dcm_reset", dcm_reset, 1);
    chk("midrel_counts", {lock_loss_cnt, retry_cnt}, 0);
    chk("midrel_ready", ready, 0);
    reset = 1'b0;
    wait_ready(100);

    // Short button pulse ignored; long one re-sequences exactly once
    sw_rst = 1'b1; repeat (5) cycle();
    sw_rst = 1'b0; repeat (30) cycle();
    chk("short_button_ready", ready, 1);
    falls = 0; prev = ready;
    for (int i = 0; i < 150; i++) begin
      sw_rst = (i < 20);
      cycle();
      if (prev && !ready) falls++;
      prev = ready;
    end
    chk("long_button_resequences", falls, 1);
    chk("long_button_ready_again", ready, 1);
    chk("long_button_loss_cnt", lock_loss_cnt, 0);

    // Lock bouncing in WAIT_LOCK, then stable
    do_reset();
    for (int c = 0; c < 64; c++) begin
      locked = ((c / 4) % 2 == 0);
      cycle();
    end
    locked = 1'b1;
    found = 0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (!rst_out[0] && found == 0) found = i;
    end
    chk("bounce_then_stable_release_delay", found, 27);

    // No lock at all: retry loop saturates
    locked = 1'b0;
    do_reset();
    for (int c = 0; c < 1800; c++) begin
      cycle();
      if (c == 103) chk("retry_before_first_tmo", retry_cnt, 0);
      if (c == 104) chk("retry_after_first_tmo", retry_cnt, 1);
    end
    chk("retry_saturated", retry_cnt, 15);
    chk("retry_no_ready", ready, 0);

    // Repeated lock loss during STRETCH saturates the loss counter
    do_reset();
    for (int p = 0; p < 300; p++) begin
      for (int j = 0; j < 20; j++) begin
        locked = (j >= 2);
        cycle();
      end
    end
    chk("loss_saturated", lock_loss_cnt, 255);

    // Randomised traffic against the model
    locked = 1'b1; sw_rst = 1'b0;
    do_reset();
    begin
      int low_left = 0;
      for (int i = 0; i < 4000; i++) begin
        if (low_left == 0 && $urandom_range(0, 49) == 0) low_left = $urandom_range(1, 4);
        locked = (low_left == 0);
        if (low_left > 0) low_left--;
        if ($urandom_range(0, 11) == 0) sw_rst = ~sw_rst;
        reset = ($urandom_range(0, 999) == 0);
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
